sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags.sv | 104 ++++++++++
 tb/tb_sync_fifo_flags.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - synchronous FIFO with count, status flags and optional sticky error flags (SYNC_FIFO_ERR_FLAGS_EN)
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AFULL_TH   = (1 << PTR_WIDTH) - 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_C  = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] AFULL_C  = AFULL_TH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AEMPTY_C = AEMPTY_TH[PTR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic [PTR_WIDTH:0]    count_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags are pure decodes of the registered count, so they follow an accept by one cycle
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  // Full blocks writes and empty blocks reads, even when the other side is active (no bypass)
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // Storage array is deliberately not reset; stale words are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= w_data;
    end
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_acc;
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr   <= rptr + 1'b1;
        r_data <= mem[rptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags; a clear on the same edge as a new error wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
  wire unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags against a queue reference model
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int PW    = 3;
  localparam int DEPTH = 1 << PW;
  localparam int AFT   = DEPTH - 1;
  localparam int AET   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic [PW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  sync_fifo_flags #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .err_clr(err_clr), .r_data(r_data), .r_valid(r_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: FIFO contents, expected read words, last read word, error flags
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] exp_rdata = '0;
  logic          m_ov = 1'b0;
  logic          m_uf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = fifo_q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AFT));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AET));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  // one clock: check state from the previous edge, then drive and predict the next edge
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    int n;
    @(negedge clk);
    check_status();
    w_en = w; w_data = d; r_en = r; err_clr = c;
    n = fifo_q.size();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    if (c) begin
      m_ov = 1'b0; m_uf = 1'b0;
    end else begin
      if (w && n == DEPTH) m_ov = 1'b1;
      if (r && n == 0) m_uf = 1'b1;
    end
`endif
    if (r && n > 0) exp_q.push_back(fifo_q.pop_front());
    if (w && n < DEPTH) fifo_q.push_back(d);
  endtask

  // monitor: checks the read port just after each rising edge
  always @(posedge clk) begin
    #1;
    chk("r_valid", 32'(r_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
    chk("r_data", 32'(r_data), 32'(exp_rdata));
  end

  initial begin
    logic [DW-1:0] v;
    #2;
    check_status();
    chk("reset_r_valid", 32'(r_valid), 32'd0);
    chk("reset_r_data", 32'(r_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fill 1..8, then a rejected 9th write
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    // drain in order, then an underflowing read
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    // hold at count 4 with simultaneous traffic across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, DW'(8'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    // both requests when empty, then when full
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // randomized traffic with drifting write/read bias
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      v = DW'($urandom);
      step($urandom_range(99) < wp, v, $urandom_range(99) < (100 - wp), $urandom_range(99) < 3);
    end

    // bring occupancy to 5, then reset mid-cycle
    while (fifo_q.size() > 5) step(1'b0, '0, 1'b1, 1'b0);
    while (fifo_q.size() < 5) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    @(negedge clk);
    check_status();
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    fifo_q.delete(); exp_q.delete(); exp_rdata = '0; m_ov = 1'b0; m_uf = 1'b0;
    #1;
    check_status();
    chk("async_r_data", 32'(r_data), 32'd0);
    chk("async_r_valid", 32'(r_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_reset_data", 32'(exp_rdata), 32'h55);
    @(negedge clk);
    check_status();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
